// File: rtl/ram2video_ml.sv
// Line-buffer to video raster generator: parametrised timing, runtime line repeat,
// RAM read-latency compensation and sticky line-buffer underrun detection.
module ram2video_ml #(
    parameter int DATA_W         = 24,
    parameter int H_TOTAL        = 858,
    parameter int H_VISIBLE      = 720,
    parameter int H_SYNC_START   = 736,
    parameter int H_SYNC_WIDTH   = 62,
    parameter int H_START_OFFSET = 0,
    parameter int PIXEL_FACTOR   = 1,
    parameter int V_TOTAL        = 525,
    parameter int V_TOTAL_ALT    = 526,
    parameter int V_VISIBLE      = 480,
    parameter int V_SYNC_START   = 489,
    parameter int V_SYNC_WIDTH   = 6,
    parameter int HS_POL         = 0,
    parameter int VS_POL         = 0,
    parameter int SLOT_BITS      = 2,
    parameter int COL_BITS       = 10,
    parameter int RAM_LATENCY    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          starttrigger,
    input  logic [1:0]                    line_repeat,
    input  logic                          add_line,
    input  logic [SLOT_BITS-1:0]          wr_slot,
    input  logic [DATA_W-1:0]             rddata,
    output logic [SLOT_BITS+COL_BITS-1:0] rdaddr,
    output logic [DATA_W/3-1:0]           red,
    output logic [DATA_W/3-1:0]           green,
    output logic [DATA_W/3-1:0]           blue,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic                          frame_start,
    output logic                          line_start,
    output logic                          running,
    output logic                          underrun,
    output logic                          videoClock
);

    localparam int          CW         = DATA_W / 3;
    localparam logic [11:0] LP_HT_M1   = 12'(H_TOTAL - 1);
    localparam logic [11:0] LP_HV      = 12'(H_VISIBLE);
    localparam logic [11:0] LP_HSS     = 12'(H_SYNC_START);
    localparam logic [11:0] LP_HSE     = 12'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [11:0] LP_HSO     = 12'(H_START_OFFSET);
    localparam logic [11:0] LP_HSO_END = 12'(H_START_OFFSET + H_VISIBLE);
    localparam logic [11:0] LP_VT_M1   = 12'(V_TOTAL - 1);
    localparam logic [11:0] LP_VTA_M1  = 12'(V_TOTAL_ALT - 1);
    localparam logic [11:0] LP_VV      = 12'(V_VISIBLE);
    localparam logic [11:0] LP_VSS     = 12'(V_SYNC_START);
    localparam logic [11:0] LP_VSE     = 12'(V_SYNC_START + V_SYNC_WIDTH);
    localparam logic        LP_HS_ACT  = 1'(HS_POL);
    localparam logic        LP_VS_ACT  = 1'(VS_POL);

    // Flag vector bit positions: {frame_start, line_start, vsync, hsync, de}
    localparam int F_DE = 0, F_HS = 1, F_VS = 2, F_LS = 3, F_FS = 4;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_lr_q;
    logic                 r_al_q;
    logic [11:0]          r_x;
    logic [11:0]          r_y;
    logic [1:0]           r_rep;
    logic [SLOT_BITS-1:0] r_src;
    logic [4:0]           r_pipe [RAM_LATENCY+1];
    logic [DATA_W-1:0]    r_rgb;
    logic                 r_underrun;

    logic                 w_mode_change;
    logic                 w_clear;
    logic                 w_x_wrap;
    logic                 w_y_wrap;
    logic                 w_rep_wrap;
    logic [11:0]          w_vt_m1;
    logic [11:0]          w_xoff;
    logic [11:0]          w_col_full;
    logic                 w_col_in;
    logic [COL_BITS-1:0]  w_col;
    logic [4:0]           w_flags0;
    logic [4:0]           w_flags_out;

    assign w_mode_change = (r_state == ST_RUN) &&
                           ((line_repeat != r_lr_q) || (add_line != r_al_q));
    // Counters and alignment pipeline only advance while a raster is genuinely running.
    assign w_clear       = (r_state == ST_IDLE) || w_mode_change;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (starttrigger)  w_state_next = ST_RUN;
            ST_RUN:  if (w_mode_change) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        r_lr_q <= line_repeat;
        r_al_q <= add_line;
    end

    assign w_vt_m1    = r_al_q ? LP_VTA_M1 : LP_VT_M1;
    assign w_x_wrap   = (r_x == LP_HT_M1);
    assign w_y_wrap   = (r_y == w_vt_m1);
    assign w_rep_wrap = (r_rep == r_lr_q);

    always_ff @(posedge clock) begin
        if (!reset || w_clear) begin
            r_x   <= '0;
            r_y   <= '0;
            r_rep <= '0;
            r_src <= '0;
        end else if (w_x_wrap) begin
            r_x <= '0;
            if (w_y_wrap) begin
                r_y   <= '0;
                r_rep <= '0;
                r_src <= '0;
            end else begin
                r_y <= r_y + 12'd1;
                if (w_rep_wrap) begin
                    r_rep <= '0;
                    r_src <= r_src + 1'b1;
                end else begin
                    r_rep <= r_rep + 2'd1;
                end
            end
        end else begin
            r_x <= r_x + 12'd1;
        end
    end

    assign w_xoff     = r_x - LP_HSO;
    assign w_col_full = (PIXEL_FACTOR == 2) ? {1'b0, w_xoff[11:1]} : w_xoff;
    assign w_col_in   = (r_x >= LP_HSO) && (r_x < LP_HSO_END);
    assign w_col      = w_col_in ? w_col_full[COL_BITS-1:0] : '1;
    assign rdaddr     = {r_src, w_col};

    // vsync edges land on the hsync leading edge of the first and last+1 sync lines.
    always_comb begin
        w_flags0       = '0;
        w_flags0[F_DE] = (r_x < LP_HV) && (r_y < LP_VV);
        w_flags0[F_HS] = (r_x >= LP_HSS) && (r_x < LP_HSE);
        w_flags0[F_VS] = ((r_y == LP_VSS) && (r_x >= LP_HSS)) ||
                         ((r_y > LP_VSS) && (r_y < LP_VSE)) ||
                         ((r_y == LP_VSE) && (r_x < LP_HSS));
        w_flags0[F_LS] = (r_x == 12'd0);
        w_flags0[F_FS] = (r_x == 12'd0) && (r_y == 12'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset || w_clear) begin
            for (int i = 0; i <= RAM_LATENCY; i++) r_pipe[i] <= '0;
            r_rgb <= '0;
        end else begin
            r_pipe[0] <= w_flags0;
            for (int i = 1; i <= RAM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            // rddata now belongs to the flags one stage short of the output.
            r_rgb <= r_pipe[RAM_LATENCY-1][F_DE] ? rddata : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || w_mode_change || ((r_state == ST_IDLE) && starttrigger))
            r_underrun <= 1'b0;
        else if ((r_state == ST_RUN) && (r_x == 12'd0) && (r_rep == 2'd0) &&
                 (r_y < LP_VV) && (r_src == wr_slot))
            r_underrun <= 1'b1;
    end

    assign w_flags_out = r_pipe[RAM_LATENCY];
    assign de          = w_flags_out[F_DE];
    assign hsync       = w_flags_out[F_HS] ? LP_HS_ACT : ~LP_HS_ACT;
    assign vsync       = w_flags_out[F_VS] ? LP_VS_ACT : ~LP_VS_ACT;
    assign line_start  = w_flags_out[F_LS];
    assign frame_start = w_flags_out[F_FS];
    assign red         = r_rgb[3*CW-1:2*CW];
    assign green       = r_rgb[2*CW-1:CW];
    assign blue        = r_rgb[CW-1:0];
    assign running     = (r_state == ST_RUN);
    assign underrun    = r_underrun;
    assign videoClock  = clock;

endmodule

// File: tb/tb_ram2video_ml.sv
// Bench for ram2video_ml: small raster geometry, address-echo RAM with latency,
// cycle-by-cycle comparison against a position-arithmetic raster model.
module tb_ram2video_ml;

    localparam int HT = 40, HV = 24, HSS = 28, HSW = 5, HSO = 2, PF = 2;
    localparam int VT0 = 20, VT1 = 21, VV = 12, VSS = 14, VSW = 3;
    localparam int HSP = 1, VSP = 0, SB = 2, CB = 10, LAT = 2, DW = 24;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           starttrigger = 1'b0;
    logic [1:0]     line_repeat = 2'd0;
    logic           add_line = 1'b0;
    logic [SB-1:0]  wr_slot = '0;
    logic [DW-1:0]  rddata;
    logic [SB+CB-1:0] rdaddr;
    logic [DW/3-1:0] red, green, blue;
    logic hsync, vsync, de, frame_start, line_start, running, underrun, videoClock;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_run = 0;
    int         m_n   = 0;
    int         m_und = 0;
    logic [1:0] m_lr  = 2'd0;
    logic       m_al  = 1'b0;

    ram2video_ml #(
        .DATA_W(DW), .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_START(HSS),
        .H_SYNC_WIDTH(HSW), .H_START_OFFSET(HSO), .PIXEL_FACTOR(PF),
        .V_TOTAL(VT0), .V_TOTAL_ALT(VT1), .V_VISIBLE(VV), .V_SYNC_START(VSS),
        .V_SYNC_WIDTH(VSW), .HS_POL(HSP), .VS_POL(VSP), .SLOT_BITS(SB),
        .COL_BITS(CB), .RAM_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset), .starttrigger(starttrigger),
        .line_repeat(line_repeat), .add_line(add_line), .wr_slot(wr_slot),
        .rddata(rddata), .rdaddr(rdaddr), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
        .line_start(line_start), .running(running), .underrun(underrun),
        .videoClock(videoClock)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] ram_word(input logic [SB+CB-1:0] a);
        return {a, a ^ 12'hA5C};
    endfunction

    // RAM: word for an address appears on rddata LAT clocks after the address.
    logic [DW-1:0] ram_pipe [LAT];
    always @(posedge clock) begin
        ram_pipe[0] <= ram_word(rdaddr);
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign rddata = ram_pipe[LAT-1];

    function automatic int vt_of(input logic al);
        return al ? VT1 : VT0;
    endfunction

    function automatic logic [SB+CB-1:0] exp_addr(input int n, input logic [1:0] lr, input logic al);
        int x, y, src, col;
        logic [SB-1:0] s;
        logic [CB-1:0] c;
        x   = n % HT;
        y   = (n / HT) % vt_of(al);
        src = (y / (int'(lr) + 1)) % (1 << SB);
        col = (x >= HSO && x < HSO + HV) ? ((x - HSO) / PF) % (1 << CB) : (1 << CB) - 1;
        s   = SB'(src);
        c   = CB'(col);
        return {s, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (model n=%0d)", tag, got, exp, $time, m_n);
        end
    endtask

    task automatic check_outputs();
        int n_out, x, y, p;
        logic act, e_de, e_hs, e_vs, e_ls, e_fs;
        logic [DW-1:0] e_rgb;
        act   = (m_run != 0) && (m_n >= LAT + 1);
        n_out = m_n - (LAT + 1);
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_rgb = '0;
        if (act) begin
            x = n_out % HT;
            y = (n_out / HT) % vt_of(m_al);
            p = y * HT + x;
            e_de = (x < HV) && (y < VV);
            e_hs = (x >= HSS) && (x < HSS + HSW);
            e_vs = (p >= VSS * HT + HSS) && (p < (VSS + VSW) * HT + HSS);
            e_ls = (x == 0);
            e_fs = (x == 0) && (y == 0);
            if (e_de) e_rgb = ram_word(exp_addr(n_out, m_lr, m_al));
        end
        check("running", 32'(running), 32'(m_run));
        check("rdaddr", 32'(rdaddr), 32'(exp_addr((m_run != 0) ? m_n : 0, m_lr, m_al)));
        check("de", 32'(de), 32'(e_de));
        check("hsync", 32'(hsync), 32'(e_hs ? HSP : 1 - HSP));
        check("vsync", 32'(vsync), 32'(e_vs ? VSP : 1 - VSP));
        check("line_start", 32'(line_start), 32'(e_ls));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("rgb", 32'({red, green, blue}), 32'(e_rgb));
        check("underrun", 32'(underrun), 32'(m_und));
        check("videoclk", 32'(videoClock), 32'(clock));
    endtask

    // One clock: compare against the model, drive new inputs, advance the model.
    task automatic step(input logic rst, input logic trig, input logic [1:0] lr,
                        input logic al, input logic [SB-1:0] ws);
        int x, y;
        @(negedge clock);
        check_outputs();
        reset = rst; starttrigger = trig; line_repeat = lr; add_line = al; wr_slot = ws;
        if (!rst) begin
            m_run = 0; m_n = 0; m_und = 0;
        end else if ((m_run != 0) && ((lr != m_lr) || (al != m_al))) begin
            m_run = 0; m_n = 0; m_und = 0;
        end else if (m_run == 0) begin
            if (trig) begin
                m_run = 1; m_n = 0; m_und = 0;
            end
        end else begin
            x = m_n % HT;
            y = (m_n / HT) % vt_of(m_al);
            if ((x == 0) && ((y % (int'(m_lr) + 1)) == 0) && (y < VV) &&
                (exp_addr(m_n, m_lr, m_al) >> CB) == 12'(ws))
                m_und = 1;
            m_n++;
        end
        m_lr = lr;
        m_al = al;
    endtask

    initial begin
        logic [1:0] r_lr;
        logic       r_al;
        int         len;
        repeat (5) step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        repeat (5) step(1'b1, 1'b0, 2'd0, 1'b0, 2'd2);
        // 1x repeat, slot 2 being written: underrun expected on line 2
        repeat (1700) step(1'b1, 1'b1, 2'd0, 1'b0, 2'd2);
        // mode change while trigger held high: stop, then restart next clock
        repeat (1800) step(1'b1, 1'b1, 2'd1, 1'b0, 2'd3);
        // 4x repeat with a trigger pulse
        repeat (4) step(1'b1, 1'b0, 2'd3, 1'b0, 2'd1);
        step(1'b1, 1'b1, 2'd3, 1'b0, 2'd1);
        repeat (1000) step(1'b1, 1'b0, 2'd3, 1'b0, 2'd1);
        // add_line toggled mid-frame, then re-triggered for 21-line frames
        repeat (5) step(1'b1, 1'b0, 2'd3, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd3, 1'b1, 2'd0);
        repeat (1900) step(1'b1, 1'b0, 2'd3, 1'b1, 2'd0);
        // randomized segments
        repeat (14) begin
            r_lr = 2'($urandom_range(0, 3));
            r_al = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(20, 1500));
            if ($urandom_range(0, 5) == 0) repeat (2) step(1'b0, 1'b0, r_lr, r_al, 2'd0);
            repeat (len)
                step(1'b1, $urandom_range(0, 7) == 0, r_lr, r_al, 2'($urandom_range(0, 3)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
